// File: rtl/async_preset_pkg.sv
// Shared defaults, legal parameter ranges and counter sizing for the async_preset block.
package async_preset_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    localparam int CNT_W       = 8;
    localparam int STRETCH_DEF = 4;
    localparam int STRETCH_MIN = 1;
    localparam int STRETCH_MAX = (1 << CNT_W) - 1;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic bit in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/async_preset_sync.sv
// Generic multi-stage level synchronizer with synchronous active-high reset.
module async_preset_sync
    import async_preset_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d,
    output logic [STAGES-1:0] q
);

    // q[0] is the only flop fed from outside the clock domain (ASYNC_REG / false path on its D).
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= {q[STAGES-2:0], d};
        end
    end

endmodule

// File: rtl/async_preset.sv
// Captures narrow asynchronous preset pulses and emits one synchronous pulse per event.
// Optional macro ASYNC_PRESET_STRETCH_EN widens each pulse to STRETCH_CYCLES cycles.
module async_preset
    import async_preset_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int STRETCH_CYCLES = STRETCH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic preset_in,
    output logic q_out
);

    logic                   cap;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_next;
    logic                   rise_p0;

    if (!in_range(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX)) begin : g_bad_sync
        $error("async_preset: SYNC_STAGES out of range");
    end
    if (!in_range(STRETCH_CYCLES, STRETCH_MIN, STRETCH_MAX)) begin : g_bad_stretch
        $error("async_preset: STRETCH_CYCLES out of range");
    end

    // The set path wins over every clear, so a preset during reset is still captured.
    always_ff @(posedge clk or posedge preset_in) begin
        if (preset_in) begin
            cap <= 1'b1;
        end else if (rst || sync[0]) begin
            cap <= 1'b0;
        end
    end

    async_preset_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (cap),
        .q  (sync)
    );

    // Edge taken against the last stage's incoming value so q_out rises with sync[last].
    assign sync_next = sync[SYNC_STAGES-2];
    assign rise_p0   = sync_next & ~sync[SYNC_STAGES-1];

`ifdef ASYNC_PRESET_STRETCH_EN
    cnt_t cnt;

    // A new event reloads the counter; overlapping events extend rather than queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            q_out <= 1'b0;
        end else if (rise_p0) begin
            cnt   <= cnt_t'(STRETCH_CYCLES - 1);
            q_out <= 1'b1;
        end else if (cnt != '0) begin
            cnt   <= cnt - cnt_t'(1);
            q_out <= 1'b1;
        end else begin
            q_out <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            q_out <= 1'b0;
        end else begin
            q_out <= rise_p0;
        end
    end
`endif

endmodule

// File: tb/tb_async_preset.sv
// Randomized self-checking bench for async_preset; the model predicts q_out as time windows.
module tb_async_preset;

    localparam int SYNC_STAGES    = 2;
    localparam int STRETCH_CYCLES = 4;
    localparam int PERIOD         = 20;
`ifdef ASYNC_PRESET_STRETCH_EN
    localparam int WIDTH = STRETCH_CYCLES;
`else
    localparam int WIDTH = 1;
`endif

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic preset_in = 1'b0;
    logic q_out;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pulses = 0;
    int   rises[$];
    bit   cmp_en   = 1'b0;
    logic q_prev   = 1'b0;

    async_preset #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STRETCH_CYCLES(STRETCH_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .preset_in(preset_in),
        .q_out    (q_out)
    );

    always #(PERIOD/2) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Each event owns a window of WIDTH cycles starting at its predicted rise edge.
    function automatic bit model_q(input int t);
        foreach (rises[i]) begin
            if (rises[i] <= t && t < rises[i] + WIDTH * PERIOD) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) chk("q_out", 32'(q_out), 32'(model_q(int'($time) - PERIOD/2)));
        if (q_out === 1'b1 && q_prev !== 1'b1) n_pulses <= n_pulses + 1;
        q_prev <= q_out;
    end

    // Pulse of width w, off time units after a rising edge; output is that edge's time.
    task automatic fire(input int off, input int w, input bit model, output int p);
        @(posedge clk);
        p = int'($time);
        #(off) preset_in = 1'b1;
        #(w)   preset_in = 1'b0;
        if (model) rises.push_back(p + SYNC_STAGES * PERIOD);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int p;
        int base;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_q_out", 32'(q_out), 32'd0);
        chk("reset_cap", 32'(dut.cap), 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        base = n_pulses;
        fire(5, 1, 1'b1, p);
        idle(8);
        chk("single_count", 32'(n_pulses - base), 32'd1);

        base = n_pulses;
        for (int i = 0; i < 8; i++) begin
            fire(int'($urandom_range(2, 15)), int'($urandom_range(1, 2)), 1'b1, p);
            idle(int'($urandom_range(7, 10)));
        end
        idle(WIDTH + 4);
        chk("random_count", 32'(n_pulses - base), 32'd8);

        base = n_pulses;
        fire(5, 40, 1'b1, p);
        #140;
        fire(5, 1, 1'b1, p);
        idle(WIDTH + 8);
        chk("long_count", 32'(n_pulses - base), 32'd2);

        base = n_pulses;
        fire(3, 1, 1'b1, p);
        #9 preset_in = 1'b1;
        #1 preset_in = 1'b0;
        idle(WIDTH + 8);
        chk("double_count", 32'(n_pulses - base), 32'd1);

        // Reset lands while the first pulse is high and a second event is in flight.
        fire(5, 1, 1'b1, p);
        repeat (3) @(negedge clk);
        chk("pre_rst_q_out", 32'(q_out), 32'd1);
        cmp_en = 1'b0;
        rst = 1'b1;
        #15 preset_in = 1'b1;
        #1  preset_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_q_out", 32'(q_out), 32'd0);
        end
        rst = 1'b0;
        base = n_pulses;
        idle(12);
        chk("post_rst_le1", 32'(n_pulses - base <= 1), 32'd1);
        rises.delete();
        @(negedge clk);
        cmp_en = 1'b1;

`ifdef ASYNC_PRESET_STRETCH_EN
        base = n_pulses;
        fire(5, 1, 1'b1, p);
        #79 preset_in = 1'b1;
        #1  preset_in = 1'b0;
        rises.push_back(p + 80 + SYNC_STAGES * PERIOD);
        idle(14);
        chk("stretch_merge_count", 32'(n_pulses - base), 32'd1);
`endif

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
